// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch-operand and multiply/divide stalls, plus branch flush.
// Optional HAZARD_PERF_CNT_EN adds a 32-bit stall_cnt output counting stalled cycles.
module hazard_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] if_id_rs,
  input  logic [4:0] if_id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_branch,
  input  logic       id_store,
  input  logic       id_mfhilo,
  input  logic       id_md,
  input  logic       branch_taken,
  input  logic       id_ex_regwrite,
  input  logic       id_ex_memread,
  input  logic [4:0] id_ex_rd,
  input  logic       ex_mem_memread,
  input  logic [4:0] ex_mem_rd,
  input  logic       ex_md_start,
  input  logic       ex_md_div,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       id_ex_flush,
  output logic       if_id_flush,
  output logic       md_busy,
  output logic       md_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT - 1);

  md_state_t  state;
  logic [5:0] count;

  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic load_use, br_haz, md_haz, stall;

  // NOTE: always_comb uses blocking assignments; every output gets a value on every path, so no latch.
  always_comb begin
    rs_ex  = id_uses_rs && (id_ex_rd  != 5'd0) && (id_ex_rd  == if_id_rs);
    rt_ex  = id_uses_rt && (id_ex_rd  != 5'd0) && (id_ex_rd  == if_id_rt);
    rs_mem = id_uses_rs && (ex_mem_rd != 5'd0) && (ex_mem_rd == if_id_rs);
    rt_mem = id_uses_rt && (ex_mem_rd != 5'd0) && (ex_mem_rd == if_id_rt);

    // Store data on rt is forwarded in MEM, so only the rs match stalls a store.
    load_use = id_ex_memread && (rs_ex || (rt_ex && !id_store));
    br_haz   = id_branch && ((id_ex_regwrite && (rs_ex || rt_ex)) ||
                             (ex_mem_memread && (rs_mem || rt_mem)));
    md_haz   = (id_mfhilo || id_md) && ((state != IDLE) || ex_md_start);
    stall    = load_use || br_haz || md_haz;
  end

  assign pc_write    = !stall;
  assign if_id_write = !stall;
  assign id_ex_flush = stall;
  assign if_id_flush = id_branch && branch_taken && !stall;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= 6'd0;
      md_busy <= 1'b0;
      md_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_md_start) begin
            count   <= ex_md_div ? DIV_LOAD : MUL_LOAD;
            state   <= BUSY;
            md_busy <= 1'b1;
          end
        end
        BUSY: begin
          if (count == 6'd0) begin
            state   <= DONE;
            md_busy <= 1'b0;
            md_done <= 1'b1;
          end else begin
            count <= count - 6'd1;
          end
        end
        DONE: begin
          md_done <= 1'b0;
          if (ex_md_start) begin
            count   <= ex_md_div ? DIV_LOAD : MUL_LOAD;
            state   <= BUSY;
            md_busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          md_busy <= 1'b0;
          md_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     stall_cnt <= 32'd0;
    else if (stall) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios plus random stimulus vs a window-based reference model.
module tb_hazard_ctrl;
  localparam int MUL_LAT = 12;
  localparam int DIV_LAT = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] if_id_rs, if_id_rt, id_ex_rd, ex_mem_rd;
  logic       id_uses_rs, id_uses_rt, id_branch, id_store, id_mfhilo, id_md;
  logic       branch_taken, id_ex_regwrite, id_ex_memread, ex_mem_memread;
  logic       ex_md_start, ex_md_div;
  logic       pc_write, if_id_write, id_ex_flush, if_id_flush, md_busy, md_done;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .id_store(id_store), .id_mfhilo(id_mfhilo), .id_md(id_md),
    .branch_taken(branch_taken),
    .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .ex_mem_memread(ex_mem_memread), .ex_mem_rd(ex_mem_rd),
    .ex_md_start(ex_md_start), .ex_md_div(ex_md_div),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_flush(id_ex_flush),
    .if_id_flush(if_id_flush), .md_busy(md_busy), .md_done(md_done)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt, ex_rd, mem_rd;
    logic uses_rs, uses_rt, branch, store, mfhilo, md, taken;
    logic ex_regwrite, ex_memread, mem_memread, md_start, md_div;
  } stim_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  // The multiply/divide unit is modelled as time windows: busy in [busy_from, busy_to], done at done_at.
  int          busy_from = -10, busy_to = -10, done_at = -10;
  int unsigned exp_cnt  = 0;
  logic        obs_busy, obs_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic stim_t nop();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic bit reads(input stim_t s, input logic [4:0] rd);
    return (rd != 0) && ((s.uses_rs && rd == s.rs) || (s.uses_rt && rd == s.rt));
  endfunction

  task automatic drive(input stim_t s);
    if_id_rs = s.rs; if_id_rt = s.rt; id_uses_rs = s.uses_rs; id_uses_rt = s.uses_rt;
    id_branch = s.branch; id_store = s.store; id_mfhilo = s.mfhilo; id_md = s.md;
    branch_taken = s.taken; id_ex_regwrite = s.ex_regwrite; id_ex_memread = s.ex_memread;
    id_ex_rd = s.ex_rd; ex_mem_memread = s.mem_memread; ex_mem_rd = s.mem_rd;
    ex_md_start = s.md_start; ex_md_div = s.md_div;
  endtask

  // Drive one cycle, compare every output against the model, then advance the model past the edge.
  // exp_stall / exp_flush >= 0 add a fixed expectation taken straight from the scenario.
  task automatic apply(input stim_t s, input string tag, input int exp_stall, input int exp_flush);
    bit busy_e, done_e, lu, bh, mh, st, fl, rt_hit;
    @(negedge clk);
    drive(s);
    #1;
    busy_e = rst_n && cyc >= busy_from && cyc <= busy_to;
    done_e = rst_n && cyc == done_at;
    rt_hit = s.uses_rt && s.ex_rd != 0 && s.ex_rd == s.rt;
    lu = s.ex_memread && ((s.uses_rs && s.ex_rd != 0 && s.ex_rd == s.rs) || (rt_hit && !s.store));
    bh = s.branch && ((s.ex_regwrite && reads(s, s.ex_rd)) || (s.mem_memread && reads(s, s.mem_rd)));
    mh = (s.mfhilo || s.md) && (busy_e || done_e || s.md_start);
    st = lu || bh || mh;
    fl = s.branch && s.taken && !st;
    obs_busy = md_busy;
    obs_done = md_done;
    check({tag, ".pc_write"},    32'(pc_write),    32'(!st));
    check({tag, ".if_id_write"}, 32'(if_id_write), 32'(!st));
    check({tag, ".id_ex_flush"}, 32'(id_ex_flush), 32'(st));
    check({tag, ".if_id_flush"}, 32'(if_id_flush), 32'(fl));
    check({tag, ".md_busy"},     32'(md_busy),     32'(busy_e));
    check({tag, ".md_done"},     32'(md_done),     32'(done_e));
`ifdef HAZARD_PERF_CNT_EN
    check({tag, ".stall_cnt"},   stall_cnt,        exp_cnt);
`endif
    if (exp_stall >= 0) check({tag, ".stall_fixed"}, 32'(id_ex_flush), 32'(exp_stall));
    if (exp_flush >= 0) check({tag, ".flush_fixed"}, 32'(if_id_flush), 32'(exp_flush));
    if (st) exp_cnt++;
    if (s.md_start && !busy_e) begin
      busy_from = cyc + 1;
      busy_to   = cyc + (s.md_div ? DIV_LAT : MUL_LAT);
      done_at   = busy_to + 1;
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    stim_t s;
    int n_busy, n_done;

    rst_n = 1'b0;
    drive(nop());
    #3;
    check("reset.pc_write",    32'(pc_write),    32'd1);
    check("reset.if_id_write", 32'(if_id_write), 32'd1);
    check("reset.id_ex_flush", 32'(id_ex_flush), 32'd0);
    check("reset.if_id_flush", 32'(if_id_flush), 32'd0);
    check("reset.md_busy",     32'(md_busy),     32'd0);
    check("reset.md_done",     32'(md_done),     32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply(nop(), "idle", 0, 0);

    // Load-use on rs
    s = nop(); s.ex_memread = 1; s.ex_regwrite = 1; s.ex_rd = 8; s.rs = 8; s.uses_rs = 1;
    apply(s, "load_use", 1, 0);
    apply(nop(), "load_use_after", 0, 0);

    // Store data on rt does not stall
    s = nop(); s.ex_memread = 1; s.ex_regwrite = 1; s.ex_rd = 8; s.rt = 8; s.uses_rt = 1;
    s.store = 1; s.rs = 5; s.uses_rs = 1;
    apply(s, "store_excl", 0, 0);

    // Load to r0 never stalls
    s = nop(); s.ex_memread = 1; s.ex_rd = 0; s.rs = 0; s.uses_rs = 1;
    apply(s, "rd_zero", 0, 0);

    // Branch after a load on r9: two stall cycles, then the flush
    s = nop(); s.branch = 1; s.taken = 1; s.rs = 9; s.uses_rs = 1;
    s.ex_memread = 1; s.ex_regwrite = 1; s.ex_rd = 9;
    apply(s, "br_load_c1", 1, 0);
    s = nop(); s.branch = 1; s.taken = 1; s.rs = 9; s.uses_rs = 1;
    s.mem_memread = 1; s.mem_rd = 9;
    apply(s, "br_load_c2", 1, 0);
    s = nop(); s.branch = 1; s.taken = 1; s.rs = 9; s.uses_rs = 1;
    apply(s, "br_load_c3", 0, 1);

    // Divide with mfhi held in ID: start cycle + 32 busy + 1 done all stall
    s = nop(); s.md_start = 1; s.md_div = 1; s.mfhilo = 1;
    apply(s, "div_start", 1, -1);
    n_busy = 0; n_done = 0;
    s = nop(); s.mfhilo = 1;
    for (int i = 0; i < 33; i++) begin
      apply(s, "div_wait", 1, -1);
      n_busy += int'(obs_busy);
      if (obs_done) begin
        check("div_done_cycle", 32'(i), 32'd32);
        n_done++;
      end
    end
    check("div_busy_cycles", 32'(n_busy), 32'(DIV_LAT));
    check("div_done_count",  32'(n_done), 32'd1);
    apply(s, "div_release", 0, -1);

    // Reset in cycle 10 of a multiply
    s = nop(); s.md_start = 1;
    apply(s, "mul_start", -1, -1);
    for (int i = 0; i < 9; i++) apply(nop(), "mul_busy", -1, -1);
    @(negedge clk);
    drive(nop());
    #1;
    check("mul_c10_busy", 32'(md_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mul_rst_busy", 32'(md_busy), 32'd0);
    check("mul_rst_done", 32'(md_done), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check("mul_rst_stall_cnt", stall_cnt, 32'd0);
`endif
    busy_from = -10; busy_to = -10; done_at = -10; exp_cnt = 0;
    @(posedge clk);
    @(posedge clk);
    cyc += 3;
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      apply(nop(), "post_rst", 0, 0);
      n_done += int'(obs_done);
    end
    check("post_rst_no_done", 32'(n_done), 32'd0);

    // Random traffic, registers drawn from a small pool so matches are frequent
    for (int i = 0; i < 1500; i++) begin
      s.rs = 5'($urandom_range(0, 3));     s.rt = 5'($urandom_range(0, 3));
      s.ex_rd = 5'($urandom_range(0, 3));  s.mem_rd = 5'($urandom_range(0, 3));
      s.uses_rs = 1'($urandom);  s.uses_rt = 1'($urandom);
      s.branch = ($urandom_range(0, 3) == 0);
      s.store  = ($urandom_range(0, 3) == 0);
      s.mfhilo = ($urandom_range(0, 5) == 0);
      s.md     = ($urandom_range(0, 7) == 0);
      s.taken  = 1'($urandom);
      s.ex_regwrite = 1'($urandom);  s.ex_memread = 1'($urandom);
      s.mem_memread = 1'($urandom);
      s.md_start = ($urandom_range(0, 9) == 0);
      s.md_div   = ($urandom_range(0, 3) == 0);
      apply(s, "rand", -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4: BUSY cycles for multiply (range 2..63).
REQ-002 SHALL have parameter DIV_LAT, default 32: BUSY cycles for divide (range 2..63).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports if_id_rs, if_id_rt  input  5  source registers of the instruction in ID.
REQ-006 SHALL have ports id_uses_rs, id_uses_rt  input  1  ID instruction reads rs/rt.
REQ-007 SHALL have ports id_branch, id_store, id_mfhilo, id_md  input  1  ID is branch/jr, store, mfhi/mflo, mult/div.
REQ-008 SHALL have port branch_taken  input  1  ID comparator result (branch/jr redirects).
REQ-009 SHALL have ports id_ex_regwrite, id_ex_memread  input  1; id_ex_rd  input  5  EX-stage destination.
REQ-010 SHALL have port ex_mem_memread  input  1; ex_mem_rd  input  5  MEM-stage destination.
REQ-011 SHALL have ports ex_md_start, ex_md_div  input  1  mult/div entering EX; divide select.
REQ-012 SHALL have outputs pc_write, if_id_write, id_ex_flush, if_id_flush, md_busy, md_done  1 bit each.

Function
REQ-013 SHALL define match(rd) = rd != 0 and ((id_uses_rs and rd == if_id_rs) or (id_uses_rt and rd == if_id_rt)).
REQ-014 SHALL raise load_use = id_ex_memread and match(id_ex_rd), excluding the rt-only match when id_store=1 (store data is forwarded in MEM).
REQ-015 SHALL raise br_haz = id_branch and ((id_ex_regwrite and match(id_ex_rd)) or (ex_mem_memread and match(ex_mem_rd))); the id_store exclusion does not apply.
REQ-016 SHALL raise md_haz = (id_mfhilo or id_md) and (md FSM not IDLE or ex_md_start).
REQ-017 SHALL, when stall = load_use or br_haz or md_haz, drive pc_write=0, if_id_write=0, id_ex_flush=1 in the same cycle (combinational); otherwise 1,1,0.
REQ-018 SHALL drive if_id_flush = id_branch and branch_taken and not stall; a stall always suppresses the flush.
REQ-019 SHALL implement md FSM with states IDLE, BUSY, DONE and a 6-bit down-counter.
REQ-020 SHALL, in IDLE with ex_md_start=1, load counter with (ex_md_div ? DIV_LAT : MUL_LAT)-1 and enter BUSY next edge.
REQ-021 SHALL, in BUSY, decrement each cycle and enter DONE on the edge where counter==0; BUSY lasts exactly LAT cycles.
REQ-022 SHALL stay in DONE exactly one cycle, then enter IDLE; ex_md_start in DONE enters BUSY directly with a new count.
REQ-023 SHALL ignore ex_md_start while in BUSY (cannot occur because of REQ-016).
REQ-024 SHALL drive md_busy=1 only in BUSY and md_done=1 only in DONE (registered state decode, no glitch).
REQ-025 SHALL evaluate all hazards every cycle from current inputs; a branch after a load therefore stalls exactly 2 cycles without extra state.

Reset
REQ-026 SHALL, on rst_n low, asynchronously force state=IDLE, counter=0, md_busy=0, md_done=0, regardless of any operation in progress.
REQ-027 SHALL drive pc_write=1, if_id_write=1, id_ex_flush=0, if_id_flush=0 while in reset when no hazard inputs are asserted.
REQ-028 SHALL resume at the first rising clk after rst_n deasserts, with no ghost md_done from an aborted operation.

Configuration
REQ-029 SHALL, with HAZARD_PERF_CNT_EN defined, add output stall_cnt  output  32  count of stalled cycles, incremented each cycle stall=1, wrapping 0xFFFFFFFF->0, reset to 0.
REQ-030 SHALL, without HAZARD_PERF_CNT_EN, omit the stall_cnt port and its logic entirely; all other behaviour identical.

Verification
REQ-031 SHALL cover load-use: id_ex_memread=1, id_ex_rd=8, if_id_rs=8, id_uses_rs=1 -> pc_write=0, if_id_write=0, id_ex_flush=1 for one cycle.
REQ-032 SHALL cover store exclusion: same load, if_id_rt=8, id_uses_rt=1, id_store=1, rs unmatched -> no stall.
REQ-033 SHALL cover branch after load on r9: id_branch=1, branch_taken=1 -> stall 2 cycles with if_id_flush=0, then if_id_flush=1 in cycle 3.
REQ-034 SHALL cover divide: ex_md_start=1, ex_md_div=1 -> md_busy high 32 cycles, md_done high cycle 33; id_mfhilo held high stalls all 33 cycles plus the start cycle.
REQ-035 SHALL cover rd=0: load to r0 with if_id_rs=0 -> no stall.
REQ-036 SHALL cover reset mid-BUSY at cycle 10 of a multiply -> md_busy=0 immediately, no md_done afterwards; stall_cnt=0 when HAZARD_PERF_CNT_EN defined.
